// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller: active-low source edge capture, mask, registered CPU request
// Optional level-sensitive sources and MODE register at 0x14 when INTC_LEVEL_SRC_EN is defined.
module intr_ctrl #(
    parameter int NUM_SRC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                CS_N,
    input  logic                RD_N,
    input  logic                WR_N,
    input  logic [11:0]         Addr,
    input  logic [31:0]         DataIn,
    output logic [31:0]         DataOut,
    input  logic [NUM_SRC-1:0]  IRQ_N,
    output logic                CPU_IRQ
);

    localparam logic [11:0] ADDR_PENDING = 12'h000;
    localparam logic [11:0] ADDR_MASK    = 12'h004;
    localparam logic [11:0] ADDR_CLEAR   = 12'h008;
    localparam logic [11:0] ADDR_ID      = 12'h00C;
    localparam logic [11:0] ADDR_CTRL    = 12'h010;
`ifdef INTC_LEVEL_SRC_EN
    localparam logic [11:0] ADDR_MODE    = 12'h014;
`endif

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] prev_n;
    logic [NUM_SRC-1:0] fall;
    logic [NUM_SRC-1:0] set_bits;
    logic [NUM_SRC-1:0] clr_bits;
    logic [NUM_SRC-1:0] active;
    logic               gen;
    logic               bus_wr;
    logic               bus_rd;
    logic               id_valid;
    logic [3:0]         id_idx;
    logic               unused_data_in;

    assign bus_wr = ~CS_N & ~WR_N;
    assign bus_rd = ~CS_N & ~RD_N;
    assign fall   = prev_n & ~IRQ_N;
    assign active = pending & mask;

    assign unused_data_in = &{1'b0, DataIn};

`ifdef INTC_LEVEL_SRC_EN
    logic [NUM_SRC-1:0] mode;
    // A low level source re-asserts every cycle, so a clear only sticks once the line is high.
    assign set_bits = fall | (mode & ~IRQ_N);
`else
    assign set_bits = fall;
`endif

    assign clr_bits = (bus_wr && Addr == ADDR_CLEAR) ? DataIn[NUM_SRC-1:0] : '0;

    // Tracking IRQ_N through reset keeps a line already low at release from looking like an edge.
    always_ff @(posedge clk) begin
        prev_n <= IRQ_N;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            gen     <= 1'b0;
            CPU_IRQ <= 1'b0;
        end else begin
            pending <= (pending & ~clr_bits) | set_bits;
            if (bus_wr && Addr == ADDR_MASK) begin
                mask <= DataIn[NUM_SRC-1:0];
            end
            if (bus_wr && Addr == ADDR_CTRL) begin
                gen <= DataIn[0];
            end
            CPU_IRQ <= gen & (|active);
        end
    end

`ifdef INTC_LEVEL_SRC_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mode <= '0;
        end else if (bus_wr && Addr == ADDR_MODE) begin
            mode <= DataIn[NUM_SRC-1:0];
        end
    end
`endif

    // Scan downward so the lowest-index active source is the one left standing.
    always_comb begin
        id_valid = 1'b0;
        id_idx   = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                id_valid = 1'b1;
                id_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        DataOut = '0;
        if (bus_rd) begin
            case (Addr)
                ADDR_PENDING: DataOut[NUM_SRC-1:0] = pending;
                ADDR_MASK:    DataOut[NUM_SRC-1:0] = mask;
                ADDR_ID: begin
                    DataOut[31]  = id_valid;
                    DataOut[3:0] = id_idx;
                end
                ADDR_CTRL:    DataOut[0] = gen;
`ifdef INTC_LEVEL_SRC_EN
                ADDR_MODE:    DataOut[NUM_SRC-1:0] = mode;
`endif
                default:      DataOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - table-driven bench for intr_ctrl plus hand-written reset and level-source sequences
module tb_intr_ctrl;

    localparam logic [11:0] A_PEND  = 12'h000;
    localparam logic [11:0] A_MASK  = 12'h004;
    localparam logic [11:0] A_CLEAR = 12'h008;
    localparam logic [11:0] A_ID    = 12'h00C;
    localparam logic [11:0] A_CTRL  = 12'h010;
    localparam logic [11:0] A_MODE  = 12'h014;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n, rd_n, wr_n;
    logic [11:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  irq_n;
    logic        cpu_irq;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct {
        bit          cs;
        bit          rd;
        bit          wr;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  irq;
        logic [31:0] exp_do;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    intr_ctrl #(.NUM_SRC(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .CS_N    (cs_n),
        .RD_N    (rd_n),
        .WR_N    (wr_n),
        .Addr    (addr),
        .DataIn  (data_in),
        .DataOut (data_out),
        .IRQ_N   (irq_n),
        .CPU_IRQ (cpu_irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit cs, bit rd, bit wr, logic [11:0] a, logic [31:0] d,
                                logic [3:0] irq, logic [31:0] edo, logic eirq);
        vec_t v;
        v.cs = cs; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
        v.irq = irq; v.exp_do = edo; v.exp_irq = eirq;
        return v;
    endfunction

    function automatic vec_t wv(logic [11:0] a, logic [31:0] d, logic [3:0] irq, logic eirq);
        return mk(1, 0, 1, a, d, irq, 32'h0, eirq);
    endfunction

    function automatic vec_t rv(logic [11:0] a, logic [3:0] irq, logic [31:0] edo, logic eirq);
        return mk(1, 1, 0, a, 32'h0, irq, edo, eirq);
    endfunction

    function automatic vec_t iv(logic [3:0] irq, logic eirq);
        return mk(0, 0, 0, 12'h0, 32'h0, irq, 32'h0, eirq);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge.
    task automatic drive(input bit cs, input bit rd, input bit wr, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] irq);
        @(negedge clk);
        cs_n = ~cs; rd_n = ~rd; wr_n = ~wr;
        addr = a; data_in = d; irq_n = irq;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; data_in = '0;
        irq_n = 4'b1110;
        repeat (3) @(negedge clk);
        #1;
        check("reset CPU_IRQ", {31'h0, cpu_irq}, 32'h0);
        check("reset DataOut idle", data_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // line 0 low through reset release must not latch
        vecs.push_back(wv(A_MASK, 32'h1, 4'b1110, 0));
        vecs.push_back(wv(A_CTRL, 32'h1, 4'b1110, 0));
        vecs.push_back(rv(A_PEND, 4'b1110, 32'h0, 0));
        vecs.push_back(iv(4'b1110, 0));
        vecs.push_back(iv(4'b1111, 0));
        // single edge on source 2 and its latency
        vecs.push_back(wv(A_MASK, 32'h5, 4'b1111, 0));
        vecs.push_back(iv(4'b1011, 0));
        vecs.push_back(rv(A_PEND, 4'b1011, 32'h4, 0));
        vecs.push_back(rv(A_ID, 4'b1011, 32'h8000_0002, 1));
        vecs.push_back(wv(A_CLEAR, 32'h4, 4'b1111, 1));
        vecs.push_back(iv(4'b1111, 1));
        vecs.push_back(rv(A_PEND, 4'b1111, 32'h0, 0));
        // sources 0 and 2 together, priority and staged clears
        vecs.push_back(iv(4'b1010, 0));
        vecs.push_back(rv(A_ID, 4'b1010, 32'h8000_0000, 0));
        vecs.push_back(wv(A_CLEAR, 32'h1, 4'b1010, 1));
        vecs.push_back(rv(A_ID, 4'b1010, 32'h8000_0002, 1));
        vecs.push_back(wv(A_CLEAR, 32'h4, 4'b1010, 1));
        vecs.push_back(iv(4'b1010, 1));
        vecs.push_back(rv(A_PEND, 4'b1010, 32'h0, 0));
        vecs.push_back(iv(4'b1111, 0));
        // set beats clear in the same cycle
        vecs.push_back(wv(A_CLEAR, 32'h2, 4'b1101, 0));
        vecs.push_back(rv(A_PEND, 4'b1101, 32'h2, 0));
        vecs.push_back(wv(A_CLEAR, 32'h2, 4'b1111, 0));
        vecs.push_back(rv(A_PEND, 4'b1111, 32'h0, 0));
        // masked capture, later unmask
        vecs.push_back(wv(A_MASK, 32'h0, 4'b1111, 0));
        vecs.push_back(iv(4'b0111, 0));
        vecs.push_back(rv(A_PEND, 4'b0111, 32'h8, 0));
        vecs.push_back(wv(A_MASK, 32'h8, 4'b0111, 0));
        vecs.push_back(rv(A_MASK, 4'b1111, 32'h8, 0));
        vecs.push_back(iv(4'b1111, 1));
        // map holes, write-only/readback registers, overlap, chip select
        vecs.push_back(rv(A_MODE, 4'b1111, 32'h0, 1));
        vecs.push_back(wv(12'h020, 32'hFFFF_FFFF, 4'b1111, 1));
        vecs.push_back(rv(A_CLEAR, 4'b1111, 32'h0, 1));
        vecs.push_back(rv(A_CTRL, 4'b1111, 32'h1, 1));
        vecs.push_back(rv(A_ID, 4'b1111, 32'h8000_0003, 1));
        vecs.push_back(mk(1, 1, 1, A_MASK, 32'h0, 4'b1111, 32'h8, 1));
        vecs.push_back(rv(A_MASK, 4'b1111, 32'h0, 1));
        vecs.push_back(iv(4'b1111, 0));
        vecs.push_back(mk(0, 1, 0, A_PEND, 32'h0, 4'b1111, 32'h0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].irq);
            check($sformatf("vec%0d DataOut", i), data_out, vecs[i].exp_do);
            check($sformatf("vec%0d CPU_IRQ", i), {31'h0, cpu_irq}, {31'h0, vecs[i].exp_irq});
        end

        // reset in the middle of a bus write with a request active
        drive(1, 0, 1, A_MASK, 32'hF, 4'b1111);
        drive(0, 0, 0, 12'h0, 32'h0, 4'b1111);
        drive(0, 0, 0, 12'h0, 32'h0, 4'b1111);
        check("pre-reset CPU_IRQ", {31'h0, cpu_irq}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        cs_n = 1'b0; wr_n = 1'b0; addr = A_MASK; data_in = 32'hF;
        @(negedge clk);
        reset = 1'b0;
        cs_n = 1'b1; wr_n = 1'b1;
        #1;
        check("mid-reset CPU_IRQ", {31'h0, cpu_irq}, 32'h0);
        drive(1, 1, 0, A_PEND, 32'h0, 4'b1111);
        check("mid-reset PENDING", data_out, 32'h0);
        drive(1, 1, 0, A_MASK, 32'h0, 4'b1111);
        check("mid-reset MASK", data_out, 32'h0);
        drive(1, 1, 0, A_CTRL, 32'h0, 4'b1111);
        check("mid-reset CTRL", data_out, 32'h0);

`ifdef INTC_LEVEL_SRC_EN
        drive(1, 0, 1, A_MODE, 32'h1, 4'b1111);
        drive(1, 0, 1, A_MASK, 32'h1, 4'b1111);
        drive(1, 0, 1, A_CTRL, 32'h1, 4'b1111);
        drive(1, 1, 0, A_MODE, 32'h0, 4'b1111);
        check("level MODE readback", data_out, 32'h1);
        drive(0, 0, 0, 12'h0, 32'h0, 4'b1110);
        drive(1, 0, 1, A_CLEAR, 32'h1, 4'b1110);
        drive(1, 1, 0, A_PEND, 32'h0, 4'b1110);
        check("level clear while low", data_out, 32'h1);
        check("level CPU_IRQ", {31'h0, cpu_irq}, 32'h1);
        drive(0, 0, 0, 12'h0, 32'h0, 4'b1111);
        drive(1, 1, 0, A_PEND, 32'h0, 4'b1111);
        check("level held after release", data_out, 32'h1);
        drive(1, 0, 1, A_CLEAR, 32'h1, 4'b1111);
        drive(1, 1, 0, A_PEND, 32'h0, 4'b1111);
        check("level clear after release", data_out, 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
